hazard_forward_ctrl: RTL and testbench
======================================

HAZARD_FORWARD_CTRL -- requirements
Module: hazard_forward_ctrl

Interface
REQ-001 Parameter NUM_SRC, default 3, number of ID-stage source operands (Rn, Rm, store-data Rd).
REQ-002 Parameter REG_AW, default 4, register-address width.
REQ-003 Parameter LOAD_LAT, default 1, range 1..7, number of stall cycles per load-use hazard.
REQ-004 Parameter NO_FWD_REG, default 15, register never forwarded (PC).
REQ-005 Parameter CNT_W, default 16, width of the stall event counter.
REQ-006 clk  in  1  single clock, all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 id_src_valid  in  NUM_SRC  per-source "operand used" flag.
REQ-009 id_src_reg  in  NUM_SRC*REG_AW  source register addresses, source i at bits [i*REG_AW +: REG_AW].
REQ-010 ex_rd, mem_rd, wb_rd  in  REG_AW each  destination registers of the EX, MEM and WB stages.
REQ-011 ex_rf_enable, mem_rf_enable, wb_rf_enable  in  1 each  stage will write the register file.
REQ-012 ex_load  in  1  instruction in EX is a load.
REQ-013 mux_sel  out  2*NUM_SRC  per-source forward select, source i at bits [2i+1:2i].
REQ-014 pc_ld_en, if_id_ld_en  out  1 each  load enables for PC and IF/ID (0 = hold).
REQ-015 id_ex_nop  out  1  insert a bubble into ID/EX.
REQ-016 stall_count  out  CNT_W  saturating count of stalled cycles.

Function
REQ-017 The select encoding SHALL be 00 = register file, 01 = EX, 10 = MEM, 11 = WB.
REQ-018 For each source i, mux_sel SHALL be combinational and SHALL use priority EX > MEM > WB.
REQ-019 A stage SHALL match source i only when id_src_valid[i]=1, the stage rf_enable=1, its rd equals id_src_reg[i], and id_src_reg[i] != NO_FWD_REG.
REQ-020 When no stage matches, mux_sel for source i SHALL be 00.
REQ-021 A load-use hazard SHALL be detected when ex_load=1 and the EX stage matches any source.
REQ-022 The FSM SHALL have two states, RUN and STALL, plus a down-counter stall_cnt of width 3.
REQ-023 In RUN with a hazard detected: stall outputs (pc_ld_en=0, if_id_ld_en=0, id_ex_nop=1) SHALL be asserted in the same cycle.
REQ-024 In RUN with a hazard detected and LOAD_LAT>1: the next state SHALL be STALL with stall_cnt=LOAD_LAT-2.
REQ-025 In RUN with a hazard detected and LOAD_LAT=1: the state SHALL remain RUN.
REQ-026 In STALL, the stall outputs SHALL be asserted unconditionally and stall_cnt SHALL decrement each cycle.
REQ-027 In STALL, the state SHALL return to RUN on the cycle after stall_cnt=0.
REQ-028 Total stall length per hazard SHALL be exactly LOAD_LAT cycles.
REQ-029 Hazard detection SHALL be ignored while in STALL.
REQ-030 Outside stall: pc_ld_en=1, if_id_ld_en=1, id_ex_nop=0.
REQ-031 Forwarding selects SHALL remain active during stall cycles.
REQ-032 stall_count SHALL increment by 1 on every cycle with id_ex_nop=1 and SHALL saturate at all-ones.
REQ-033 Back-to-back hazards SHALL each produce a full LOAD_LAT stall with no gap cycle merged.

Reset
REQ-034 On a clock edge with reset=1, the state SHALL become RUN, stall_cnt 0 and stall_count 0.
REQ-035 While reset=1: mux_sel SHALL be all zero, pc_ld_en=1, if_id_ld_en=1 and id_ex_nop=0.
REQ-036 Reset asserted mid-STALL SHALL abort the stall; operation resumes in RUN with no residual stall after reset deasserts.

Structure
REQ-037 Package hazard_pkg SHALL hold the select encodings (SEL_RF, SEL_EX, SEL_MEM, SEL_WB) and the state enumeration (RUN, STALL).
REQ-038 Sub-module fwd_select SHALL implement the per-source priority compare (REQ-018..020) and SHALL be instantiated NUM_SRC times by generate.
REQ-039 The FSM, counters and stall outputs SHALL reside in hazard_forward_ctrl.

Verification
REQ-040 Source 0=R3 valid, ex_rd=3 with ex_rf_enable=1, mem_rd=3 and wb_rd=3 both enabled, ex_load=0 -> mux_sel[1:0]=01, no stall.
REQ-041 Source 1=R5, mem_rd=5 and wb_rd=5 enabled, EX no match -> mux_sel[3:2]=10; with mem_rf_enable=0 -> 11; with wb_rf_enable=0 also -> 00.
REQ-042 Source 0=R15, ex_rd=15 enabled -> mux_sel[1:0]=00; source 2 with id_src_valid[2]=0 and matching reg -> 00.
REQ-043 LOAD_LAT=1, ex_load=1, ex_rd=2, source 0=R2 -> exactly 1 cycle pc_ld_en=0 and id_ex_nop=1, stall_count 0->1.
REQ-044 LOAD_LAT=3 hazard -> 3 consecutive stall cycles, stall_count=3; the same with reset pulsed in the 2nd cycle -> stall ends, state RUN, stall_count=0.
REQ-045 CNT_W=4, continuous hazards for 20 cycles -> stall_count holds at 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding control slice.
// Holds forward-select codes and FSM state constants.
package hazard_pkg;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EX  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] SEL_WB  = 2'b11;

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

endpackage

// File: rtl/fwd_select.sv
// Per-operand forward select: EX > MEM > WB > register file.
// Ports: source valid/reg, stage rd/enable, 2-bit sel out.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 4,
  parameter int NO_FWD_REG = 15
) (
  input  logic              src_valid,
  input  logic [REG_AW-1:0] src_reg,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              ex_en,
  input  logic              mem_en,
  input  logic              wb_en,
  output logic [1:0]        sel
);

  localparam logic [REG_AW-1:0] NO_FWD = REG_AW'(NO_FWD_REG);

  logic usable;
  assign usable = src_valid && (src_reg != NO_FWD);

  always_comb begin
    sel = SEL_RF;
    if (usable && ex_en && ex_rd == src_reg)
      sel = SEL_EX;
    else if (usable && mem_en && mem_rd == src_reg)
      sel = SEL_MEM;
    else if (usable && wb_en && wb_rd == src_reg)
      sel = SEL_WB;
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding select and load-use stall control.
// Ports: ID sources, EX/MEM/WB dests, mux_sel, stall enables, stall_count.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int REG_AW     = 4,
  parameter int LOAD_LAT   = 1,
  parameter int NO_FWD_REG = 15,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        id_src_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src_reg,
  input  logic [REG_AW-1:0]         ex_rd,
  input  logic [REG_AW-1:0]         mem_rd,
  input  logic [REG_AW-1:0]         wb_rd,
  input  logic                      ex_rf_enable,
  input  logic                      mem_rf_enable,
  input  logic                      wb_rf_enable,
  input  logic                      ex_load,
  output logic [2*NUM_SRC-1:0]      mux_sel,
  output logic                      pc_ld_en,
  output logic                      if_id_ld_en,
  output logic                      id_ex_nop,
  output logic [CNT_W-1:0]          stall_count
);

  // First STALL-state count; RUN already supplies one stall cycle.
  localparam logic [2:0] CNT_INIT =
    (LOAD_LAT > 1) ? 3'(LOAD_LAT - 2) : 3'd0;

  logic [2*NUM_SRC-1:0] sel_raw;
  logic [0:0]           state;
  logic [2:0]           stall_cnt;
  logic                 hazard;
  logic                 stall;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    fwd_select #(
      .REG_AW     (REG_AW),
      .NO_FWD_REG (NO_FWD_REG)
    ) u_sel (
      .src_valid (id_src_valid[i]),
      .src_reg   (id_src_reg[i*REG_AW +: REG_AW]),
      .ex_rd     (ex_rd),
      .mem_rd    (mem_rd),
      .wb_rd     (wb_rd),
      .ex_en     (ex_rf_enable),
      .mem_en    (mem_rf_enable),
      .wb_en     (wb_rf_enable),
      .sel       (sel_raw[2*i +: 2])
    );
  end

  // EX has top priority, so an EX match always shows as SEL_EX.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < NUM_SRC; i++)
      if (sel_raw[2*i +: 2] == SEL_EX)
        hazard = 1'b1;
    hazard = hazard && ex_load;
  end

  assign stall       = !reset && ((state == STALL) || hazard);
  assign mux_sel     = reset ? '0 : sel_raw;
  assign pc_ld_en    = !stall;
  assign if_id_ld_en = !stall;
  assign id_ex_nop   = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      stall_cnt   <= 3'd0;
      stall_count <= '0;
    end else begin
      if (state == RUN) begin
        if (hazard && (LOAD_LAT > 1)) begin
          state     <= STALL;
          stall_cnt <= CNT_INIT;
        end
      end else begin
        if (stall_cnt == 3'd0)
          state <= RUN;
        else
          stall_cnt <= stall_cnt - 3'd1;
      end
      if (id_ex_nop && (stall_count != '1))
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench: three DUT configs share stimulus.
// Stimulus queues expectations; a negedge monitor checks them.
module tb_hazard_forward_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  id_src_valid;
  logic [11:0] id_src_reg;
  logic [3:0]  ex_rd, mem_rd, wb_rd;
  logic        ex_rf_enable, mem_rf_enable, wb_rf_enable;
  logic        ex_load;

  logic [5:0]  sel_a, sel_b, sel_c;
  logic        pc_a, pc_b, pc_c;
  logic        ifid_a, ifid_b, ifid_c;
  logic        nop_a, nop_b, nop_c;
  logic [15:0] sc_a, sc_b;
  logic [3:0]  sc_c;

  always #5 clk = ~clk;

  hazard_forward_ctrl #(.LOAD_LAT(1)) u_a (
    .clk(clk), .reset(reset),
    .id_src_valid(id_src_valid), .id_src_reg(id_src_reg),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rf_enable(ex_rf_enable), .mem_rf_enable(mem_rf_enable),
    .wb_rf_enable(wb_rf_enable), .ex_load(ex_load),
    .mux_sel(sel_a), .pc_ld_en(pc_a), .if_id_ld_en(ifid_a),
    .id_ex_nop(nop_a), .stall_count(sc_a)
  );

  hazard_forward_ctrl #(.LOAD_LAT(3)) u_b (
    .clk(clk), .reset(reset),
    .id_src_valid(id_src_valid), .id_src_reg(id_src_reg),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rf_enable(ex_rf_enable), .mem_rf_enable(mem_rf_enable),
    .wb_rf_enable(wb_rf_enable), .ex_load(ex_load),
    .mux_sel(sel_b), .pc_ld_en(pc_b), .if_id_ld_en(ifid_b),
    .id_ex_nop(nop_b), .stall_count(sc_b)
  );

  hazard_forward_ctrl #(.LOAD_LAT(1), .CNT_W(4)) u_c (
    .clk(clk), .reset(reset),
    .id_src_valid(id_src_valid), .id_src_reg(id_src_reg),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_rf_enable(ex_rf_enable), .mem_rf_enable(mem_rf_enable),
    .wb_rf_enable(wb_rf_enable), .ex_load(ex_load),
    .mux_sel(sel_c), .pc_ld_en(pc_c), .if_id_ld_en(ifid_c),
    .id_ex_nop(nop_c), .stall_count(sc_c)
  );

  typedef struct {
    int          inst;
    int          field;
    logic [15:0] exp;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // field: 0 mux_sel, 1 pc_ld_en, 2 if_id_ld_en, 3 id_ex_nop, 4 stall_count
  function automatic logic [15:0] get(int inst, int field);
    logic [15:0] v;
    v = '0;
    case (inst)
      0: case (field)
        0: v = {10'b0, sel_a};
        1: v = {15'b0, pc_a};
        2: v = {15'b0, ifid_a};
        3: v = {15'b0, nop_a};
        default: v = sc_a;
      endcase
      1: case (field)
        0: v = {10'b0, sel_b};
        1: v = {15'b0, pc_b};
        2: v = {15'b0, ifid_b};
        3: v = {15'b0, nop_b};
        default: v = sc_b;
      endcase
      default: case (field)
        0: v = {10'b0, sel_c};
        1: v = {15'b0, pc_c};
        2: v = {15'b0, ifid_c};
        3: v = {15'b0, nop_c};
        default: v = {12'b0, sc_c};
      endcase
    endcase
    return v;
  endfunction

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e   = sb.pop_front();
      act = get(e.inst, e.field);
      n_chk++;
      if (act === e.exp)
        n_pass++;
      else
        $display("FAIL %s inst%0d: got %0h expected %0h",
                 e.name, e.inst, act, e.exp);
    end
  end

  task automatic expect_v(int inst, int field,
                          logic [15:0] v, string name);
    exp_t e;
    e.inst  = inst;
    e.field = field;
    e.exp   = v;
    e.name  = name;
    sb.push_back(e);
  endtask

  // Stall trio: pc/if_id enables inverse of nop.
  task automatic expect_stall(int inst, logic s, string name);
    expect_v(inst, 1, {15'b0, !s}, {name, "_pc"});
    expect_v(inst, 2, {15'b0, !s}, {name, "_ifid"});
    expect_v(inst, 3, {15'b0, s},  {name, "_nop"});
  endtask

  task automatic clr();
    id_src_valid  = '0;
    id_src_reg    = '0;
    ex_rd         = '0;
    mem_rd        = '0;
    wb_rd         = '0;
    ex_rf_enable  = 1'b0;
    mem_rf_enable = 1'b0;
    wb_rf_enable  = 1'b0;
    ex_load       = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic load_hazard();
    clr();
    id_src_valid     = 3'b001;
    id_src_reg[3:0]  = 4'd2;
    ex_rd            = 4'd2;
    ex_rf_enable     = 1'b1;
    ex_load          = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    clr();
    nxt();
    // reset gates outputs even with a live load-use match
    load_hazard();
    ex_rd = 4'd2;
    expect_v(0, 0, 16'h0, "rst_sel");
    expect_stall(0, 1'b0, "rst");
    expect_v(0, 4, 16'd0, "rst_cnt");
    expect_stall(1, 1'b0, "rst_b");

    nxt();
    reset = 1'b0;
    clr();
    id_src_valid    = 3'b001;
    id_src_reg[3:0] = 4'd3;
    ex_rd = 4'd3; mem_rd = 4'd3; wb_rd = 4'd3;
    ex_rf_enable = 1'b1; mem_rf_enable = 1'b1; wb_rf_enable = 1'b1;
    expect_v(0, 0, 16'h01, "prio_ex");
    expect_stall(0, 1'b0, "prio_ex");

    nxt();
    clr();
    id_src_valid    = 3'b010;
    id_src_reg[7:4] = 4'd5;
    mem_rd = 4'd5; wb_rd = 4'd5;
    mem_rf_enable = 1'b1; wb_rf_enable = 1'b1;
    expect_v(0, 0, 16'h08, "prio_mem");

    nxt();
    mem_rf_enable = 1'b0;
    expect_v(0, 0, 16'h0c, "prio_wb");

    nxt();
    wb_rf_enable = 1'b0;
    expect_v(0, 0, 16'h00, "no_match");

    nxt();
    clr();
    id_src_valid    = 3'b001;
    id_src_reg[3:0] = 4'd15;
    ex_rd = 4'd15; ex_rf_enable = 1'b1;
    expect_v(0, 0, 16'h00, "no_fwd_pc");

    nxt();
    clr();
    id_src_reg[11:8] = 4'd7;
    ex_rd = 4'd7; ex_rf_enable = 1'b1;
    expect_v(0, 0, 16'h00, "src_invalid");

    nxt();
    id_src_valid = 3'b100;
    expect_v(0, 0, 16'h10, "src2_ex");

    nxt();
    reset = 1'b1;
    clr();
    expect_v(0, 4, 16'd0, "no_stall_cnt");

    // single load-use hazard: 1 cycle on A, 3 on B
    nxt();
    reset = 1'b0;
    load_hazard();
    expect_stall(0, 1'b1, "ll1_c0");
    expect_v(0, 4, 16'd0, "ll1_cnt0");
    expect_v(0, 0, 16'h01, "ll1_sel");
    expect_stall(1, 1'b1, "ll3_c0");
    expect_v(1, 4, 16'd0, "ll3_cnt0");

    nxt();
    ex_load = 1'b0;
    expect_stall(0, 1'b0, "ll1_c1");
    expect_v(0, 4, 16'd1, "ll1_cnt1");
    expect_stall(1, 1'b1, "ll3_c1");
    expect_v(1, 0, 16'h01, "ll3_fwd_in_stall");
    expect_v(1, 4, 16'd1, "ll3_cnt1");

    nxt();
    clr();
    expect_v(0, 4, 16'd1, "ll1_cnt_hold");
    expect_stall(1, 1'b1, "ll3_c2");
    expect_v(1, 4, 16'd2, "ll3_cnt2");

    nxt();
    expect_stall(1, 1'b0, "ll3_c3");
    expect_v(1, 4, 16'd3, "ll3_cnt3");

    nxt();
    expect_stall(1, 1'b0, "ll3_c4");
    expect_v(1, 4, 16'd3, "ll3_cnt_hold");

    // reset in the second stall cycle aborts the stall
    nxt();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
    load_hazard();
    expect_stall(1, 1'b1, "abort_c0");

    nxt();
    reset = 1'b1;
    clr();
    id_src_valid    = 3'b001;
    id_src_reg[3:0] = 4'd2;
    ex_rd = 4'd2; ex_rf_enable = 1'b1;
    expect_stall(1, 1'b0, "abort_rst");
    expect_v(1, 0, 16'h00, "abort_rst_sel");
    expect_v(1, 4, 16'd1, "abort_cnt_pre");

    nxt();
    reset = 1'b0;
    clr();
    expect_stall(1, 1'b0, "abort_c2");
    expect_v(1, 4, 16'd0, "abort_cnt");

    nxt();
    expect_stall(1, 1'b0, "abort_c3");
    expect_v(1, 4, 16'd0, "abort_cnt_hold");

    // continuous hazards: back-to-back stalls, CNT_W=4 saturation
    nxt();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nxt();
      reset = 1'b0;
      load_hazard();
      expect_stall(2, 1'b1, $sformatf("sat_nop%0d", i));
      expect_v(2, 4, 16'((i > 15) ? 15 : i),
               $sformatf("sat_cnt%0d", i));
      expect_v(1, 3, 16'd1, $sformatf("b2b_nop%0d", i));
      expect_v(1, 4, 16'(i), $sformatf("b2b_cnt%0d", i));
    end

    nxt();
    clr();
    expect_v(2, 4, 16'd15, "sat_hold");
    expect_stall(2, 1'b0, "sat_end");

    nxt();
    nxt();
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d entries left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
